// File: rtl/fd_pkg.sv
// Shared definitions for the fetch/decode stage: opcodes, instruction field positions, FSM states.
// Optional JMP handling in fetch_decode is enabled by defining FD_JUMP_EN.
package fd_pkg;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_JMP  = 5'h1E;
  localparam logic [4:0] OP_HALT = 5'h1F;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int RDST_MSB   = 26;
  localparam int RDST_LSB   = 22;
  localparam int RSRC1_MSB  = 21;
  localparam int RSRC1_LSB  = 17;
  localparam int RSRC2_MSB  = 16;
  localparam int RSRC2_LSB  = 12;
  localparam int IMM_MSB    = 11;
  localparam int IMM_LSB    = 0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_MEM,
    ISSUE,
    HALT
  } fd_state_t;

endpackage

// File: rtl/instr_split.sv
// Purely combinational split of a 32-bit instruction word into its five fields.
module instr_split
  import fd_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  opcode,
  output logic [4:0]  rdst,
  output logic [4:0]  rsrc1,
  output logic [4:0]  rsrc2,
  output logic [11:0] imm
);

  assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
  assign rdst   = instr[RDST_MSB:RDST_LSB];
  assign rsrc1  = instr[RSRC1_MSB:RSRC1_LSB];
  assign rsrc2  = instr[RSRC2_MSB:RSRC2_LSB];
  assign imm    = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: fetches words, registers decoded fields and holds enable until done.
// Define FD_JUMP_EN to resolve JMP locally (pc <= imm) instead of issuing it downstream.
module fetch_decode
  import fd_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                IMEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [31:0]       imem_data,
  input  logic              imem_valid,
  output logic [4:0]        opcode,
  output logic [4:0]        rdst,
  output logic [4:0]        rsrc1,
  output logic [4:0]        rsrc2,
  output logic [11:0]       imm,
  output logic              enable,
  input  logic              done,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  // The stage keeps one request outstanding and simply waits for imem_valid,
  // so the latency only has to lie in the supported range.
  generate
    if ((IMEM_LAT < 1) || (IMEM_LAT > 4)) begin : g_bad_imem_lat
      $error("fetch_decode: IMEM_LAT must be in 1..4");
    end
  endgenerate

  fd_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              capture;

  logic [4:0]  split_opcode, split_rdst, split_rsrc1, split_rsrc2;
  logic [11:0] split_imm;

  logic [4:0]  opcode_reg, rdst_reg, rsrc1_reg, rsrc2_reg;
  logic [11:0] imm_reg;

  instr_split u_split (
    .instr  (imem_data),
    .opcode (split_opcode),
    .rdst   (split_rdst),
    .rsrc1  (split_rsrc1),
    .rsrc2  (split_rsrc2),
    .imm    (split_imm)
  );

`ifdef FD_JUMP_EN
  logic [ADDR_W-1:0] jmp_target;
  // Size cast truncates for narrow PCs and zero-extends for wide ones.
  assign jmp_target = ADDR_W'(split_imm);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_reg <= '0;
      rdst_reg   <= '0;
      rsrc1_reg  <= '0;
      rsrc2_reg  <= '0;
      imm_reg    <= '0;
    end else if (capture) begin
      opcode_reg <= split_opcode;
      rdst_reg   <= split_rdst;
      rsrc1_reg  <= split_rsrc1;
      rsrc2_reg  <= split_rsrc2;
      imm_reg    <= split_imm;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          pc_next    = RESET_PC;
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = WAIT_MEM;
      end
      WAIT_MEM: begin
        if (imem_valid) begin
          capture = 1'b1;
          case (split_opcode)
            OP_NOP: begin
              pc_next    = pc_reg + ADDR_W'(1);
              state_next = FETCH;
            end
            OP_HALT: begin
              state_next = HALT;
            end
`ifdef FD_JUMP_EN
            OP_JMP: begin
              pc_next    = jmp_target;
              state_next = FETCH;
            end
`endif
            default: begin
              state_next = ISSUE;
            end
          endcase
        end
      end
      ISSUE: begin
        // done has priority; start is never looked at in this state.
        if (done) begin
          pc_next    = pc_reg + ADDR_W'(1);
          state_next = FETCH;
        end
      end
      HALT: begin
        if (start) begin
          pc_next    = RESET_PC;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status outputs decode straight from the state register so reset drops them at once.
  assign imem_rd   = (state_reg == FETCH);
  assign enable    = (state_reg == ISSUE);
  assign halted    = (state_reg == HALT);
  assign imem_addr = pc_reg;
  assign pc        = pc_reg;

  assign opcode = opcode_reg;
  assign rdst   = rdst_reg;
  assign rsrc1  = rsrc1_reg;
  assign rsrc2  = rsrc2_reg;
  assign imm    = imm_reg;

endmodule
